// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL gear controller: state encoding,
// gear index width and a constant-foldable ceil(log2) helper.
package adpll_pkg;

   typedef enum logic [1:0] {
      SEEK   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int GEAR_W = 2;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adpll_gear_ctrl_err_window.sv
// Observation window: free-running window counter plus saturating
// phase-error accumulator; latches the completed window's count at wend.
module err_window
   import adpll_pkg::*;
#(
   parameter int WIN_LEN = 256,
   parameter int ERR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             pd_err,
   output logic             wend,
   output logic [ERR_W-1:0] err_sum,
   output logic [ERR_W-1:0] win_err
);

   localparam int                WCNT_W  = clog2(WIN_LEN);
   localparam logic [WCNT_W-1:0] WCNT_TC = WCNT_W'(WIN_LEN - 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [ERR_W-1:0]  acc_q, acc_d;
   logic [ERR_W-1:0]  win_err_q, win_err_d;
   logic [ERR_W:0]    sum_ext;

   always_comb begin
      sum_ext   = {1'b0, acc_q} + {{ERR_W{1'b0}}, pd_err};
      err_sum   = sum_ext[ERR_W] ? '1 : sum_ext[ERR_W-1:0];
      wend      = ~freeze & (wcnt_q == WCNT_TC);
      wcnt_d    = wcnt_q;
      acc_d     = acc_q;
      win_err_d = win_err_q;
      if (!freeze) begin
         if (wend) begin
            // The final cycle's pd_err is folded into the reported count.
            wcnt_d    = '0;
            acc_d     = '0;
            win_err_d = err_sum;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
            acc_d  = err_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q    <= '0;
         acc_q     <= '0;
         win_err_q <= '0;
      end else begin
         wcnt_q    <= wcnt_d;
         acc_q     <= acc_d;
         win_err_q <= win_err_d;
      end
   end

   assign win_err = win_err_q;

endmodule

// File: rtl/adpll_gear_ctrl.sv
// ADPLL loop-bandwidth controller: steps the loop-filter gear from
// per-window phase-error counts and declares lock at the top gear.
//   state  | meaning
//   SEEK   | evaluate windows; climb gear on good runs, drop one on a bad window
//   SETTLE | ignore SETTLE_WINS window ends after a gear change
//   LOCKED | top gear reached; BAD_WINS bad windows in a row force relock
module adpll_gear_ctrl
   import adpll_pkg::*;
#(
   parameter int WIN_LEN     = 256,
   parameter int ERR_W       = 8,
   parameter int LOCK_THR    = 8,
   parameter int UNLOCK_THR  = 32,
   parameter int GOOD_WINS   = 4,
   parameter int BAD_WINS    = 2,
   parameter int SETTLE_WINS = 1,
   parameter int GEAR_MAX    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pd_err,
   input  logic              freeze,
   output logic [GEAR_W-1:0] gear,
   output logic              gear_chg,
   output logic              locked,
   output logic [1:0]        state,
   output logic [ERR_W-1:0]  win_err
);

   localparam int                GOOD_W   = clog2(GOOD_WINS + 2);
   localparam int                BAD_W    = clog2(BAD_WINS + 2);
   localparam int                SET_W    = clog2(SETTLE_WINS + 2);
   localparam logic [GOOD_W-1:0] GOOD_TC  = GOOD_W'(GOOD_WINS);
   localparam logic [BAD_W-1:0]  BAD_TC   = BAD_W'(BAD_WINS);
   localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_WINS);
   localparam logic [GEAR_W-1:0] GEAR_TOP = GEAR_W'(GEAR_MAX);
   // With no settle windows a gear change lands straight back in SEEK.
   localparam state_t            SETTLE_ENTRY = (SETTLE_WINS == 0) ? SEEK : SETTLE;

   logic              wend;
   logic [ERR_W-1:0]  err_sum;
   logic              win_good, win_bad;
   state_t            state_q, state_d;
   logic [GEAR_W-1:0] gear_q, gear_d;
   logic              gear_chg_q, gear_chg_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
   logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;

   err_window #(
      .WIN_LEN (WIN_LEN),
      .ERR_W   (ERR_W)
   ) u_win (
      .clk     (clk),
      .rst     (rst),
      .freeze  (freeze),
      .pd_err  (pd_err),
      .wend    (wend),
      .err_sum (err_sum),
      .win_err (win_err)
   );

   assign win_good = (int'(err_sum) <= LOCK_THR);
   assign win_bad  = (int'(err_sum) >  UNLOCK_THR);

   always_comb begin
      state_d      = state_q;
      gear_d       = gear_q;
      gear_chg_d   = 1'b0;
      good_cnt_d   = good_cnt_q;
      bad_cnt_d    = bad_cnt_q;
      settle_cnt_d = settle_cnt_q;
      if (wend) begin
         case (state_q)
            SEEK: begin
               if (win_good) begin
                  if (good_cnt_q + 1'b1 == GOOD_TC) begin
                     good_cnt_d = '0;
                     if (gear_q != GEAR_TOP) begin
                        gear_d       = gear_q + 1'b1;
                        gear_chg_d   = 1'b1;
                        state_d      = SETTLE_ENTRY;
                        settle_cnt_d = SET_LOAD;
                     end else begin
                        state_d   = LOCKED;
                        bad_cnt_d = '0;
                     end
                  end else begin
                     good_cnt_d = good_cnt_q + 1'b1;
                  end
               end else if (win_bad && (gear_q != '0)) begin
                  gear_d       = gear_q - 1'b1;
                  gear_chg_d   = 1'b1;
                  good_cnt_d   = '0;
                  state_d      = SETTLE_ENTRY;
                  settle_cnt_d = SET_LOAD;
               end else begin
                  good_cnt_d = '0;
               end
            end
            SETTLE: begin
               if (settle_cnt_q > SET_W'(1)) begin
                  settle_cnt_d = settle_cnt_q - 1'b1;
               end else begin
                  settle_cnt_d = '0;
                  state_d      = SEEK;
               end
            end
            LOCKED: begin
               if (win_bad) begin
                  if (bad_cnt_q + 1'b1 == BAD_TC) begin
                     bad_cnt_d    = '0;
                     gear_d       = '0;
                     gear_chg_d   = (gear_q != '0);
                     good_cnt_d   = '0;
                     state_d      = SETTLE_ENTRY;
                     settle_cnt_d = SET_LOAD;
                  end else begin
                     bad_cnt_d = bad_cnt_q + 1'b1;
                  end
               end else begin
                  bad_cnt_d = '0;
               end
            end
            default: state_d = SEEK;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SEEK;
         gear_q       <= '0;
         gear_chg_q   <= 1'b0;
         good_cnt_q   <= '0;
         bad_cnt_q    <= '0;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         gear_q       <= gear_d;
         gear_chg_q   <= gear_chg_d;
         good_cnt_q   <= good_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   assign gear     = gear_q;
   assign gear_chg = gear_chg_q & ~freeze;
   assign locked   = (state_q == LOCKED);
   assign state    = state_q;

endmodule

// File: tb/tb_adpll_gear_ctrl.sv
// Directed bench for adpll_gear_ctrl: checkpoint table for the main
// sequence plus hand-written freeze, async-reset and wide-window cases.
module tb_adpll_gear_ctrl;

   typedef struct {
      int upto;
      int pd;
      int gear;
      int chg;
      int lk;
      int st;
      int werr;
      int cwerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pd_a = 1'b0, frz_a = 1'b0, pd_b = 1'b0;

   logic [1:0] gear_a, st_a, gear_b, st_b, gear_c, st_c;
   logic       chg_a, lk_a, chg_b, lk_b, chg_c, lk_c;
   logic [7:0] werr_a, werr_b;
   logic [2:0] werr_c;

   int   n_vec = 0;
   int   n_err = 0;
   int   ecnt  = 0;
   vec_t tbl[27];

   always #5 clk = ~clk;

   adpll_gear_ctrl #(
      .WIN_LEN(16), .ERR_W(8), .LOCK_THR(8), .UNLOCK_THR(12),
      .GOOD_WINS(2), .BAD_WINS(2), .SETTLE_WINS(1), .GEAR_MAX(3)
   ) dut_a (
      .clk(clk), .rst(rst), .pd_err(pd_a), .freeze(frz_a),
      .gear(gear_a), .gear_chg(chg_a), .locked(lk_a), .state(st_a), .win_err(werr_a)
   );

   adpll_gear_ctrl #(
      .WIN_LEN(64), .ERR_W(8), .LOCK_THR(8), .UNLOCK_THR(32),
      .GOOD_WINS(2), .BAD_WINS(2), .SETTLE_WINS(1), .GEAR_MAX(3)
   ) dut_b (
      .clk(clk), .rst(rst), .pd_err(pd_b), .freeze(1'b0),
      .gear(gear_b), .gear_chg(chg_b), .locked(lk_b), .state(st_b), .win_err(werr_b)
   );

   adpll_gear_ctrl #(
      .WIN_LEN(16), .ERR_W(3), .LOCK_THR(8), .UNLOCK_THR(12),
      .GOOD_WINS(2), .BAD_WINS(2), .SETTLE_WINS(1), .GEAR_MAX(3)
   ) dut_c (
      .clk(clk), .rst(rst), .pd_err(pd_a), .freeze(frz_a),
      .gear(gear_c), .gear_chg(chg_c), .locked(lk_c), .state(st_c), .win_err(werr_c)
   );

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, ecnt, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      pd_a  = 1'b0;
      frz_a = 1'b0;
      pd_b  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      ecnt = 0;
   endtask

   task automatic chk_a(input string tag, input int g, input int c, input int l, input int s, input int w);
      chk({tag, "_gear"},   int'(gear_a), g);
      chk({tag, "_chg"},    int'(chg_a),  c);
      chk({tag, "_locked"}, int'(lk_a),   l);
      chk({tag, "_state"},  int'(st_a),   s);
      chk({tag, "_winerr"}, int'(werr_a), w);
   endtask

   task automatic run_table(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         while (ecnt < tbl[r].upto) begin
            pd_a = (tbl[r].pd != 0);
            step();
            if (ecnt != tbl[r].upto) chk("chg_idle", int'(chg_a), 0);
         end
         chk_a("tbl", tbl[r].gear, tbl[r].chg, tbl[r].lk, tbl[r].st, tbl[r].werr);
         chk("tbl_sat_winerr", int'(werr_c), tbl[r].cwerr);
      end
   endtask

   initial begin
      //            upto  pd gear chg lk st werr cwerr
      tbl[0]  = '{  16,  0,  0,  0, 0, 0,  0, 0};
      tbl[1]  = '{  31,  0,  0,  0, 0, 0,  0, 0};
      tbl[2]  = '{  32,  0,  1,  1, 0, 1,  0, 0};
      tbl[3]  = '{  48,  0,  1,  0, 0, 0,  0, 0};
      tbl[4]  = '{  80,  0,  2,  1, 0, 1,  0, 0};
      tbl[5]  = '{ 128,  0,  3,  1, 0, 1,  0, 0};
      tbl[6]  = '{ 175,  0,  3,  0, 0, 0,  0, 0};
      tbl[7]  = '{ 176,  0,  3,  0, 1, 2,  0, 0};
      tbl[8]  = '{ 192,  1,  3,  0, 1, 2, 16, 7};
      tbl[9]  = '{ 207,  1,  3,  0, 1, 2, 16, 7};
      tbl[10] = '{ 208,  1,  0,  1, 0, 1, 16, 7};
      tbl[11] = '{ 224,  0,  0,  0, 0, 0,  0, 0};
      tbl[12] = '{ 240,  0,  0,  0, 0, 0,  0, 0};
      tbl[13] = '{ 249,  1,  0,  0, 0, 0,  0, 0};
      tbl[14] = '{ 256,  0,  0,  0, 0, 0,  9, 7};
      tbl[15] = '{ 272,  0,  0,  0, 0, 0,  0, 0};
      tbl[16] = '{ 288,  0,  1,  1, 0, 1,  0, 0};
      tbl[17] = '{ 304,  0,  1,  0, 0, 0,  0, 0};
      tbl[18] = '{ 312,  1,  1,  0, 0, 0,  0, 0};
      tbl[19] = '{ 320,  0,  1,  0, 0, 0,  8, 7};
      tbl[20] = '{ 336,  0,  2,  1, 0, 1,  0, 0};
      tbl[21] = '{ 352,  0,  2,  0, 0, 0,  0, 0};
      tbl[22] = '{ 364,  1,  2,  0, 0, 0,  0, 0};
      tbl[23] = '{ 368,  0,  2,  0, 0, 0, 12, 7};
      tbl[24] = '{ 381,  1,  2,  0, 0, 0, 12, 7};
      tbl[25] = '{ 384,  0,  1,  1, 0, 1, 13, 7};
      tbl[26] = '{ 400,  0,  1,  0, 0, 0,  0, 0};

      // Reset state, climb to lock, lose lock, threshold boundaries.
      do_reset();
      chk_a("reset", 0, 0, 0, 0, 0);
      run_table(0, 26);

      // Async reset from LOCKED, then the climb must repeat edge for edge.
      do_reset();
      run_table(0, 7);
      #3;
      rst = 1'b0;
      #1;
      chk_a("async_rst", 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      ecnt = 0;
      run_table(0, 7);

      // Freeze mid-window for 40 cycles: window end slips from edge 32 to 72.
      do_reset();
      repeat (16) begin pd_a = 1'b0; step(); end
      repeat (4)  begin pd_a = 1'b1; step(); end
      repeat (40) begin
         frz_a = 1'b1;
         pd_a  = 1'b1;
         step();
         chk_a("frz_hold", 0, 0, 0, 0, 0);
      end
      frz_a = 1'b0;
      pd_a  = 1'b0;
      repeat (11) step();
      chk_a("frz_pre_wend", 0, 0, 0, 0, 0);
      step();
      chk_a("frz_wend", 1, 1, 0, 1, 4);

      // 64-cycle window: 33 errors at gear 2 is bad, steps down to gear 1.
      do_reset();
      repeat (320) step();
      chk("b_gear2", int'(gear_b), 2);
      chk("b_chg2", int'(chg_b), 1);
      chk("b_settle", int'(st_b), 1);
      repeat (64) step();
      chk("b_seek_state", int'(st_b), 0);
      repeat (33) begin pd_b = 1'b1; step(); end
      pd_b = 1'b0;
      repeat (30) step();
      chk("b_pre_gear", int'(gear_b), 2);
      chk("b_pre_chg", int'(chg_b), 0);
      chk("b_pre_state", int'(st_b), 0);
      step();
      chk("b_bad_winerr", int'(werr_b), 33);
      chk("b_bad_gear", int'(gear_b), 1);
      chk("b_bad_chg", int'(chg_b), 1);
      chk("b_bad_state", int'(st_b), 1);
      step();
      chk("b_chg_width", int'(chg_b), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
